// File: rtl/cafu_fifo_pkg.sv
// Shared types, widths and the round-robin pick function for the AFU request mux FIFO.
package cafu_fifo_pkg;

   localparam int ID_W   = 12;
   localparam int USER_W = 6;
   localparam int ADDR_W = 64;
   localparam int DATA_W = 512;
   localparam int STRB_W = 64;
   localparam int RR_MAX = 16;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [USER_W-1:0] user;
      logic [ADDR_W-1:0] addr;
   } rd_req_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [USER_W-1:0] user;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
      logic              last;
   } wr_req_t;

   typedef enum logic [1:0] {
      ISSUE_IDLE,
      ISSUE_RD,
      ISSUE_WR
   } issue_state_t;

   // Returns {found, index}; the first requester at or after ptr (mod n) wins.
   function automatic logic [4:0] rr_pick(input logic [RR_MAX-1:0] req,
                                          input logic [3:0]        ptr,
                                          input int                n);
      logic [4:0] res;
      logic [3:0] idx4;
      int         idx;
      res = '0;
      for (int i = RR_MAX - 1; i >= 0; i--) begin
         if (i < n) begin
            idx  = (int'(ptr) + i) % n;
            idx4 = idx[3:0];
            if (req[idx4]) res = {1'b1, idx4};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/cafu_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is read combinationally, no push-to-pop bypass.
module cafu_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok, pop_ok;

   always_comb begin
      count    = wr_ptr_q - rd_ptr_q;
      full     = (count == (AW+1)'(DEPTH));
      empty    = (count == '0);
      push_ok  = push & ~full;
      pop_ok   = pop & ~empty;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
      head     = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/cafu_req_mux_fifo.sv
// Round-robin AR / AW+W request collector with buffered issue onto one CXL AXI4 master port.
// state      | meaning
// ISSUE_IDLE | serial mode: choosing the next direction
// ISSUE_RD   | serial mode: presenting the read head until AR handshake
// ISSUE_WR   | serial mode: presenting the write head until both AW and W complete
module cafu_req_mux_fifo
   import cafu_fifo_pkg::*;
#(
   parameter int RD_CH        = 1,
   parameter int WR_CH        = 1,
   parameter int DEPTH        = 16,
   parameter int ISSUE_MODE   = 0,
   parameter int WR_BURST_MAX = 4,
   parameter int CW           = $clog2(DEPTH) + 1
) (
   input  logic                            axi4_mm_clk,
   input  logic                            axi4_mm_rst,
   input  logic [RD_CH-1:0]                arvalid_ch,
   output logic [RD_CH-1:0]                arready_ch,
   input  logic [RD_CH-1:0][ID_W-1:0]      arid_ch,
   input  logic [RD_CH-1:0][USER_W-1:0]    aruser_ch,
   input  logic [RD_CH-1:0][ADDR_W-1:0]    araddr_ch,
   input  logic [WR_CH-1:0]                awvalid_ch,
   output logic [WR_CH-1:0]                awready_ch,
   input  logic [WR_CH-1:0][ID_W-1:0]      awid_ch,
   input  logic [WR_CH-1:0][USER_W-1:0]    awuser_ch,
   input  logic [WR_CH-1:0][ADDR_W-1:0]    awaddr_ch,
   input  logic [WR_CH-1:0]                wvalid_ch,
   output logic [WR_CH-1:0]                wready_ch,
   input  logic [WR_CH-1:0][DATA_W-1:0]    wdata_ch,
   input  logic [WR_CH-1:0][STRB_W-1:0]    wstrb_ch,
   input  logic [WR_CH-1:0]                wlast_ch,
   output logic                            arvalid,
   input  logic                            arready,
   output logic [ID_W-1:0]                 arid,
   output logic [USER_W-1:0]               aruser,
   output logic [ADDR_W-1:0]               araddr,
   output logic                            awvalid,
   input  logic                            awready,
   output logic [ID_W-1:0]                 awid,
   output logic [USER_W-1:0]               awuser,
   output logic [ADDR_W-1:0]               awaddr,
   output logic                            wvalid,
   input  logic                            wready,
   output logic [DATA_W-1:0]               wdata,
   output logic [STRB_W-1:0]               wstrb,
   output logic                            wlast,
   output logic [CW-1:0]                   rd_count,
   output logic [CW-1:0]                   wr_count
);

   logic             out_en_q, out_en_d, gate;
   logic [3:0]       rr_rd_q, rr_rd_d, rr_wr_q, rr_wr_d;
   logic [4:0]       rd_pick, wr_pick;
   logic [RR_MAX-1:0] rd_req16, wr_req16;
   rd_req_t          rd_push_data, rd_head;
   wr_req_t          wr_push_data, wr_head;
   logic             rd_push, rd_pop, rd_full, rd_empty;
   logic             wr_push, wr_pop, wr_full, wr_empty;
   logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic             aw_hs, w_hs, ar_hs, rd_sel, wr_sel;
   issue_state_t     state_q, state_d;
   logic [7:0]       burst_q, burst_d;

   // Holds every ready/valid low through reset and the first cycle after release.
   assign out_en_d = 1'b1;
   assign gate     = out_en_q & ~axi4_mm_rst;

   always_comb begin
      rd_req16 = '0;
      wr_req16 = '0;
      rd_req16[RD_CH-1:0] = arvalid_ch;
      wr_req16[WR_CH-1:0] = awvalid_ch & wvalid_ch;
      rd_pick      = rr_pick(rd_req16, rr_rd_q, RD_CH);
      wr_pick      = rr_pick(wr_req16, rr_wr_q, WR_CH);
      arready_ch   = '0;
      awready_ch   = '0;
      wready_ch    = '0;
      rd_push_data = '0;
      wr_push_data = '0;
      for (int i = 0; i < RD_CH; i++) begin
         if (rd_pick[4] && (rd_pick[3:0] == 4'(i))) begin
            arready_ch[i]     = gate & ~rd_full;
            rd_push_data.id   = arid_ch[i];
            rd_push_data.user = aruser_ch[i];
            rd_push_data.addr = araddr_ch[i];
         end
      end
      for (int i = 0; i < WR_CH; i++) begin
         if (wr_pick[4] && (wr_pick[3:0] == 4'(i))) begin
            awready_ch[i]     = gate & ~wr_full;
            wready_ch[i]      = gate & ~wr_full;
            wr_push_data.id   = awid_ch[i];
            wr_push_data.user = awuser_ch[i];
            wr_push_data.addr = awaddr_ch[i];
            wr_push_data.data = wdata_ch[i];
            wr_push_data.strb = wstrb_ch[i];
            wr_push_data.last = wlast_ch[i];
         end
      end
      rd_push = |arready_ch;
      wr_push = |awready_ch;
      rr_rd_d = rr_rd_q;
      rr_wr_d = rr_wr_q;
      if (rd_push) rr_rd_d = (rd_pick[3:0] == 4'(RD_CH-1)) ? 4'd0 : rd_pick[3:0] + 4'd1;
      if (wr_push) rr_wr_d = (wr_pick[3:0] == 4'(WR_CH-1)) ? 4'd0 : wr_pick[3:0] + 4'd1;
   end

   cafu_sync_fifo #(.WIDTH($bits(rd_req_t)), .DEPTH(DEPTH)) u_rd_fifo (
      .clk       (axi4_mm_clk),
      .rst       (axi4_mm_rst),
      .push      (rd_push),
      .push_data (rd_push_data),
      .pop       (rd_pop),
      .full      (rd_full),
      .empty     (rd_empty),
      .count     (rd_count),
      .head      (rd_head)
   );

   cafu_sync_fifo #(.WIDTH($bits(wr_req_t)), .DEPTH(DEPTH)) u_wr_fifo (
      .clk       (axi4_mm_clk),
      .rst       (axi4_mm_rst),
      .push      (wr_push),
      .push_data (wr_push_data),
      .pop       (wr_pop),
      .full      (wr_full),
      .empty     (wr_empty),
      .count     (wr_count),
      .head      (wr_head)
   );

   assign rd_sel = (ISSUE_MODE != 0) || (state_q == ISSUE_RD);
   assign wr_sel = (ISSUE_MODE != 0) || (state_q == ISSUE_WR);

   always_comb begin
      arvalid   = gate & rd_sel & ~rd_empty;
      awvalid   = gate & wr_sel & ~wr_empty & ~aw_done_q;
      wvalid    = gate & wr_sel & ~wr_empty & ~w_done_q;
      ar_hs     = arvalid & arready;
      aw_hs     = awvalid & awready;
      w_hs      = wvalid & wready;
      rd_pop    = ar_hs;
      wr_pop    = gate & wr_sel & ~wr_empty & (aw_done_q | aw_hs) & (w_done_q | w_hs);
      aw_done_d = wr_pop ? 1'b0 : (aw_done_q | aw_hs);
      w_done_d  = wr_pop ? 1'b0 : (w_done_q | w_hs);
      arid      = arvalid ? rd_head.id   : '0;
      aruser    = arvalid ? rd_head.user : '0;
      araddr    = arvalid ? rd_head.addr : '0;
      awid      = awvalid ? wr_head.id   : '0;
      awuser    = awvalid ? wr_head.user : '0;
      awaddr    = awvalid ? wr_head.addr : '0;
      wdata     = wvalid  ? wr_head.data : '0;
      wstrb     = wvalid  ? wr_head.strb : '0;
      wlast     = wvalid  ? wr_head.last : 1'b0;
   end

   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      if (ISSUE_MODE == 0) begin
         case (state_q)
            ISSUE_IDLE: begin
               if (!wr_empty && (rd_empty || (burst_q < 8'(WR_BURST_MAX)))) begin
                  state_d = ISSUE_WR;
                  burst_d = burst_q + 8'd1;
               end else if (!rd_empty) begin
                  state_d = ISSUE_RD;
                  burst_d = '0;
               end
            end
            ISSUE_RD: if (ar_hs)  state_d = ISSUE_IDLE;
            ISSUE_WR: if (wr_pop) state_d = ISSUE_IDLE;
            default:  state_d = ISSUE_IDLE;
         endcase
      end
      // The write burst only limits writes while a read is waiting.
      if (rd_empty) burst_d = '0;
   end

   always_ff @(posedge axi4_mm_clk) begin
      if (axi4_mm_rst) begin
         out_en_q  <= 1'b0;
         rr_rd_q   <= '0;
         rr_wr_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         state_q   <= ISSUE_IDLE;
         burst_q   <= '0;
      end else begin
         out_en_q  <= out_en_d;
         rr_rd_q   <= rr_rd_d;
         rr_wr_q   <= rr_wr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         state_q   <= state_d;
         burst_q   <= burst_d;
      end
   end

endmodule

// File: tb/tb_cafu_req_mux_fifo.sv
// Directed bench: a concurrent-mode instance (u_con) and a serial-mode instance (u_ser) share ingress/egress-ready stimulus.
module tb_cafu_req_mux_fifo;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]        arvalid_ch;
   logic [3:0][11:0]  arid_ch;
   logic [3:0][5:0]   aruser_ch;
   logic [3:0][63:0]  araddr_ch;
   logic [1:0]        awvalid_ch, wvalid_ch, wlast_ch;
   logic [1:0][11:0]  awid_ch;
   logic [1:0][5:0]   awuser_ch;
   logic [1:0][63:0]  awaddr_ch;
   logic [1:0][511:0] wdata_ch;
   logic [1:0][63:0]  wstrb_ch;
   logic              arready, awready, wready;

   logic [3:0]   arready_ch_c, arready_ch_s;
   logic [1:0]   awready_ch_c, awready_ch_s, wready_ch_c, wready_ch_s;
   logic         arvalid_c, awvalid_c, wvalid_c, wlast_c;
   logic         arvalid_s, awvalid_s, wvalid_s, wlast_s;
   logic [11:0]  arid_c, awid_c, arid_s, awid_s;
   logic [5:0]   aruser_c, awuser_c, aruser_s, awuser_s;
   logic [63:0]  araddr_c, awaddr_c, araddr_s, awaddr_s;
   logic [511:0] wdata_c, wdata_s;
   logic [63:0]  wstrb_c, wstrb_s;
   logic [2:0]   rd_count_c, wr_count_c;
   logic [3:0]   rd_count_s, wr_count_s;

   int pass_cnt = 0;
   int total_cnt = 0;

   cafu_req_mux_fifo #(.RD_CH(4), .WR_CH(2), .DEPTH(4), .ISSUE_MODE(1), .WR_BURST_MAX(2)) u_con (
      .axi4_mm_clk(clk), .axi4_mm_rst(rst),
      .arvalid_ch(arvalid_ch), .arready_ch(arready_ch_c), .arid_ch(arid_ch), .aruser_ch(aruser_ch), .araddr_ch(araddr_ch),
      .awvalid_ch(awvalid_ch), .awready_ch(awready_ch_c), .awid_ch(awid_ch), .awuser_ch(awuser_ch), .awaddr_ch(awaddr_ch),
      .wvalid_ch(wvalid_ch), .wready_ch(wready_ch_c), .wdata_ch(wdata_ch), .wstrb_ch(wstrb_ch), .wlast_ch(wlast_ch),
      .arvalid(arvalid_c), .arready(arready), .arid(arid_c), .aruser(aruser_c), .araddr(araddr_c),
      .awvalid(awvalid_c), .awready(awready), .awid(awid_c), .awuser(awuser_c), .awaddr(awaddr_c),
      .wvalid(wvalid_c), .wready(wready), .wdata(wdata_c), .wstrb(wstrb_c), .wlast(wlast_c),
      .rd_count(rd_count_c), .wr_count(wr_count_c)
   );

   cafu_req_mux_fifo #(.RD_CH(4), .WR_CH(2), .DEPTH(8), .ISSUE_MODE(0), .WR_BURST_MAX(2)) u_ser (
      .axi4_mm_clk(clk), .axi4_mm_rst(rst),
      .arvalid_ch(arvalid_ch), .arready_ch(arready_ch_s), .arid_ch(arid_ch), .aruser_ch(aruser_ch), .araddr_ch(araddr_ch),
      .awvalid_ch(awvalid_ch), .awready_ch(awready_ch_s), .awid_ch(awid_ch), .awuser_ch(awuser_ch), .awaddr_ch(awaddr_ch),
      .wvalid_ch(wvalid_ch), .wready_ch(wready_ch_s), .wdata_ch(wdata_ch), .wstrb_ch(wstrb_ch), .wlast_ch(wlast_ch),
      .arvalid(arvalid_s), .arready(arready), .arid(arid_s), .aruser(aruser_s), .araddr(araddr_s),
      .awvalid(awvalid_s), .awready(awready), .awid(awid_s), .awuser(awuser_s), .awaddr(awaddr_s),
      .wvalid(wvalid_s), .wready(wready), .wdata(wdata_s), .wstrb(wstrb_s), .wlast(wlast_s),
      .rd_count(rd_count_s), .wr_count(wr_count_s)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      arvalid_ch = '0; awvalid_ch = '0; wvalid_ch = '0;
      arready = 1'b0; awready = 1'b0; wready = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      arvalid_ch = 4'hF; awvalid_ch = 2'b11; wvalid_ch = 2'b11;
      tick();
      total_cnt++; if (arready_ch_c !== 4'b0) $display("FAIL rst_arready_ch_c got %b exp 0000", arready_ch_c); else pass_cnt++;
      total_cnt++; if ({awready_ch_c, wready_ch_c} !== 4'b0) $display("FAIL rst_awready_wready_c got %b exp 0000", {awready_ch_c, wready_ch_c}); else pass_cnt++;
      total_cnt++; if (arready_ch_s !== 4'b0) $display("FAIL rst_arready_ch_s got %b exp 0000", arready_ch_s); else pass_cnt++;
      total_cnt++; if ({rd_count_c, wr_count_c} !== 6'b0) $display("FAIL rst_counts_c got %b exp 0", {rd_count_c, wr_count_c}); else pass_cnt++;
      total_cnt++; if ({arvalid_c, awvalid_c, wvalid_c} !== 3'b0) $display("FAIL rst_valids_c got %b exp 000", {arvalid_c, awvalid_c, wvalid_c}); else pass_cnt++;
      rst = 1'b0;
      #1;
      total_cnt++; if (arready_ch_c !== 4'b0) $display("FAIL post_rst_arready_ch_c got %b exp 0000", arready_ch_c); else pass_cnt++;
      total_cnt++; if (awready_ch_s !== 2'b0) $display("FAIL post_rst_awready_ch_s got %b exp 00", awready_ch_s); else pass_cnt++;
      tick();
      total_cnt++; if (arready_ch_c !== 4'b0001) $display("FAIL live_arready_ch_c got %b exp 0001", arready_ch_c); else pass_cnt++;
      total_cnt++; if ({awready_ch_c, wready_ch_c} !== 4'b0101) $display("FAIL live_aw_w_ready_c got %b exp 0101", {awready_ch_c, wready_ch_c}); else pass_cnt++;
      do_reset();
   endtask

   task automatic test_rd_round_robin();
      for (int i = 0; i < 4; i++) begin
         araddr_ch[i] = 64'(100 + i);
         arid_ch[i]   = 12'(i);
      end
      arready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         arvalid_ch = 4'hF;
         #1;
         total_cnt++; if (arready_ch_c !== 4'(1 << (k % 4))) $display("FAIL rr_grant_%0d got %b exp %b", k, arready_ch_c, 4'(1 << (k % 4))); else pass_cnt++;
         if (k == 0) begin
            total_cnt++; if ({arvalid_c, rd_count_c} !== 4'b0) $display("FAIL rr_first_empty got %b exp 0", {arvalid_c, rd_count_c}); else pass_cnt++;
         end else begin
            total_cnt++; if (araddr_c !== 64'(100 + k - 1)) $display("FAIL rr_araddr_%0d got %0d exp %0d", k, araddr_c, 100 + k - 1); else pass_cnt++;
            total_cnt++; if ({arvalid_c, rd_count_c} !== 4'b1001) $display("FAIL rr_valid_count_%0d got %b exp 1001", k, {arvalid_c, rd_count_c}); else pass_cnt++;
         end
         tick();
      end
      arvalid_ch = '0;
      tick();
      total_cnt++; if (rd_count_c !== 3'd0) $display("FAIL rr_drained got %0d exp 0", rd_count_c); else pass_cnt++;
      do_reset();
   endtask

   task automatic test_rd_full();
      int n;
      int exp_cnt [6] = '{4, 3, 3, 3, 2, 1};
      bit exp_rdy [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      n = 0;
      for (int k = 0; k < 4; k++) begin
         arvalid_ch = 4'b0001; araddr_ch[0] = 64'(200 + n);
         #1;
         total_cnt++; if (arready_ch_c !== 4'b0001) $display("FAIL full_fill_%0d got %b exp 0001", k, arready_ch_c); else pass_cnt++;
         n++;
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         araddr_ch[0] = 64'(200 + n);
         #1;
         total_cnt++; if ({arready_ch_c, rd_count_c} !== 7'b0000_100) $display("FAIL full_stall_%0d got %b exp 0000100", k, {arready_ch_c, rd_count_c}); else pass_cnt++;
         tick();
      end
      arready = 1'b1;
      for (int j = 0; j < 6; j++) begin
         arvalid_ch   = (n < 6) ? 4'b0001 : 4'b0000;
         araddr_ch[0] = 64'(200 + n);
         #1;
         total_cnt++; if (araddr_c !== 64'(200 + j) || arvalid_c !== 1'b1) $display("FAIL drain_addr_%0d got %0d/%b exp %0d/1", j, araddr_c, arvalid_c, 200 + j); else pass_cnt++;
         total_cnt++; if (arready_ch_c[0] !== exp_rdy[j]) $display("FAIL drain_ready_%0d got %b exp %b", j, arready_ch_c[0], exp_rdy[j]); else pass_cnt++;
         total_cnt++; if (rd_count_c !== 3'(exp_cnt[j])) $display("FAIL drain_count_%0d got %0d exp %0d", j, rd_count_c, exp_cnt[j]); else pass_cnt++;
         if (exp_rdy[j]) n++;
         tick();
      end
      total_cnt++; if ({arvalid_c, rd_count_c} !== 4'b0) $display("FAIL drain_end got %b exp 0", {arvalid_c, rd_count_c}); else pass_cnt++;
      do_reset();
   endtask

   task automatic test_aw_w_split();
      awvalid_ch = 2'b01; wvalid_ch = 2'b01;
      awaddr_ch[0] = 64'd300; wdata_ch[0] = 512'hABCD; wstrb_ch[0] = 64'hFF; wlast_ch = 2'b01;
      #1;
      total_cnt++; if ({awready_ch_c, wready_ch_c} !== 4'b0101) $display("FAIL split_ingress got %b exp 0101", {awready_ch_c, wready_ch_c}); else pass_cnt++;
      tick();
      awvalid_ch = '0; wvalid_ch = '0;
      awready = 1'b1; wready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (k == 0) begin
            total_cnt++; if ({awvalid_c, wvalid_c} !== 2'b11 || awaddr_c !== 64'd300) $display("FAIL split_first got %b/%0d exp 11/300", {awvalid_c, wvalid_c}, awaddr_c); else pass_cnt++;
         end else begin
            total_cnt++; if ({awvalid_c, wvalid_c} !== 2'b01 || awaddr_c !== 64'd0) $display("FAIL split_hold_%0d got %b/%0d exp 01/0", k, {awvalid_c, wvalid_c}, awaddr_c); else pass_cnt++;
         end
         total_cnt++; if (wdata_c !== 512'hABCD || wstrb_c !== 64'hFF || wlast_c !== 1'b1) $display("FAIL split_wpayload_%0d got %0h/%0h/%b", k, wdata_c, wstrb_c, wlast_c); else pass_cnt++;
         total_cnt++; if (wr_count_c !== 3'd1) $display("FAIL split_count_%0d got %0d exp 1", k, wr_count_c); else pass_cnt++;
         tick();
      end
      wready = 1'b1;
      #1;
      total_cnt++; if ({awvalid_c, wvalid_c, wr_count_c} !== 5'b01_001) $display("FAIL split_wready got %b exp 01001", {awvalid_c, wvalid_c, wr_count_c}); else pass_cnt++;
      tick();
      total_cnt++; if ({awvalid_c, wvalid_c, wr_count_c} !== 5'b0) $display("FAIL split_popped got %b exp 0", {awvalid_c, wvalid_c, wr_count_c}); else pass_cnt++;
      do_reset();
   endtask

   task automatic test_serial_order();
      int exp_addr [7] = '{400, 401, 500, 402, 403, 501, 404};
      int idx;
      int cyc;
      bit overlap;
      for (int k = 0; k < 5; k++) begin
         awvalid_ch = 2'b01; wvalid_ch = 2'b01; awaddr_ch[0] = 64'(400 + k);
         arvalid_ch = (k < 2) ? 4'b0001 : 4'b0000; araddr_ch[0] = 64'(500 + k);
         tick();
      end
      clear_inputs();
      #1;
      total_cnt++; if ({wr_count_s, rd_count_s} !== 8'h52) $display("FAIL ser_loaded got %h exp 52", {wr_count_s, rd_count_s}); else pass_cnt++;
      arready = 1'b1; awready = 1'b1; wready = 1'b1;
      idx = 0; cyc = 0; overlap = 1'b0;
      while (idx < 7 && cyc < 60) begin
         #1;
         if (arvalid_s && (awvalid_s || wvalid_s)) overlap = 1'b1;
         if (arvalid_s || (awvalid_s && wvalid_s)) begin
            total_cnt++;
            if ((arvalid_s ? araddr_s : awaddr_s) !== 64'(exp_addr[idx]))
               $display("FAIL ser_order_%0d got %0d exp %0d", idx, arvalid_s ? araddr_s : awaddr_s, exp_addr[idx]);
            else pass_cnt++;
            idx++;
         end
         cyc++;
         tick();
      end
      total_cnt++; if (idx != 7) $display("FAIL ser_issue_count got %0d exp 7", idx); else pass_cnt++;
      total_cnt++; if (overlap !== 1'b0) $display("FAIL ser_overlap got 1 exp 0"); else pass_cnt++;
      do_reset();
   endtask

   task automatic test_concurrent();
      for (int k = 0; k < 3; k++) begin
         arvalid_ch = 4'b0001; araddr_ch[0] = 64'(600 + k);
         awvalid_ch = 2'b01; wvalid_ch = 2'b01; awaddr_ch[0] = 64'(700 + k);
         tick();
      end
      clear_inputs();
      arready = 1'b1; awready = 1'b1; wready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         #1;
         total_cnt++; if ({arvalid_c, awvalid_c, wvalid_c} !== 3'b111) $display("FAIL conc_valids_%0d got %b exp 111", j, {arvalid_c, awvalid_c, wvalid_c}); else pass_cnt++;
         total_cnt++; if (araddr_c !== 64'(600 + j) || awaddr_c !== 64'(700 + j)) $display("FAIL conc_addr_%0d got %0d/%0d exp %0d/%0d", j, araddr_c, awaddr_c, 600 + j, 700 + j); else pass_cnt++;
         total_cnt++; if (rd_count_c !== 3'(3 - j) || wr_count_c !== 3'(3 - j)) $display("FAIL conc_count_%0d got %0d/%0d exp %0d", j, rd_count_c, wr_count_c, 3 - j); else pass_cnt++;
         tick();
      end
      total_cnt++; if ({arvalid_c, awvalid_c, rd_count_c, wr_count_c} !== 8'b0) $display("FAIL conc_end got %b exp 0", {arvalid_c, awvalid_c, rd_count_c, wr_count_c}); else pass_cnt++;
      do_reset();
   endtask

   task automatic test_reset_mid_write();
      int n;
      for (int k = 0; k < 3; k++) begin
         awvalid_ch = 2'b01; wvalid_ch = 2'b01; awaddr_ch[0] = 64'(900 + k); wdata_ch[0] = 512'(k + 1);
         tick();
      end
      clear_inputs();
      #1;
      total_cnt++; if (wr_count_s !== 4'd3) $display("FAIL mid_loaded got %0d exp 3", wr_count_s); else pass_cnt++;
      awready = 1'b1;
      #1;
      total_cnt++; if ({awvalid_s, wvalid_s} !== 2'b11) $display("FAIL mid_aw got %b exp 11", {awvalid_s, wvalid_s}); else pass_cnt++;
      tick();
      awready = 1'b0;
      #1;
      total_cnt++; if ({awvalid_s, wvalid_s} !== 2'b01) $display("FAIL mid_w_pending got %b exp 01", {awvalid_s, wvalid_s}); else pass_cnt++;
      rst = 1'b1; awvalid_ch = 2'b11; wvalid_ch = 2'b11; arvalid_ch = 4'hF;
      #1;
      total_cnt++; if ({awready_ch_s, arready_ch_s} !== 6'b0) $display("FAIL mid_rst_ready got %b exp 0", {awready_ch_s, arready_ch_s}); else pass_cnt++;
      tick();
      total_cnt++; if ({awvalid_s, wvalid_s, arvalid_s} !== 3'b0) $display("FAIL mid_rst_valids got %b exp 000", {awvalid_s, wvalid_s, arvalid_s}); else pass_cnt++;
      total_cnt++; if (awaddr_s !== 64'd0 || wdata_s !== 512'd0) $display("FAIL mid_rst_payload got %0h/%0h exp 0/0", awaddr_s, wdata_s); else pass_cnt++;
      total_cnt++; if ({wr_count_s, rd_count_s} !== 8'h00) $display("FAIL mid_rst_counts got %h exp 00", {wr_count_s, rd_count_s}); else pass_cnt++;
      clear_inputs();
      rst = 1'b0;
      tick();
      tick();
      awvalid_ch = 2'b10; wvalid_ch = 2'b10; awaddr_ch[1] = 64'd800; wdata_ch[1] = 512'h55;
      #1;
      total_cnt++; if (awready_ch_s !== 2'b10) $display("FAIL new_ingress got %b exp 10", awready_ch_s); else pass_cnt++;
      tick();
      clear_inputs();
      awready = 1'b1; wready = 1'b1;
      n = 0;
      #1;
      while (!awvalid_s && n < 10) begin
         tick();
         n++;
      end
      total_cnt++; if ({awvalid_s, wvalid_s} !== 2'b11 || awaddr_s !== 64'd800 || wdata_s !== 512'h55) $display("FAIL new_issue got %b/%0d/%0h exp 11/800/55", {awvalid_s, wvalid_s}, awaddr_s, wdata_s); else pass_cnt++;
      tick();
      total_cnt++; if (wr_count_s !== 4'd0) $display("FAIL new_popped got %0d exp 0", wr_count_s); else pass_cnt++;
      do_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      clear_inputs();
      arid_ch = '0; aruser_ch = '0; araddr_ch = '0;
      awid_ch = '0; awuser_ch = '0; awaddr_ch = '0;
      wdata_ch = '0; wstrb_ch = '0; wlast_ch = '0;
      rst = 1'b1;
      test_reset();
      test_rd_round_robin();
      test_rd_full();
      test_aw_w_split();
      test_serial_order();
      test_concurrent();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
